// File: rtl/ws_seq_pkg.sv
// Shared types and elaboration helpers for the WS281x frame sequencer.
// Holds the FSM state encoding, counter width sizing and timing legality check.
package ws_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

  // Counter width for n states; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit timing_ok(input int nss, input int t0h, input int t1h,
                                   input int bits, input int lat_ticks);
    return (t0h > 0) && (t0h < t1h) && (t1h < nss) && (bits > 0) && (lat_ticks > 0);
  endfunction

endpackage

// File: rtl/ws_bit_encoder.sv
// One-wire bit-slot encoder: NS tick counter plus registered DOUT.
// DOUT is computed from the next-cycle tick and bit so it lines up with NS.
module ws_bit_encoder
  import ws_seq_pkg::*;
#(
  parameter int NSS = 64,
  parameter int T0H = 20,
  parameter int T1H = 40,
  localparam int NS_W = cnt_w(NSS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            en,
  input  logic            dout_en,
  input  logic            bit_val,
  output logic [NS_W-1:0] ns,
  output logic            dout,
  output logic            bit_end
);

  localparam logic [31:0] T0H_U = 32'(T0H);
  localparam logic [31:0] T1H_U = 32'(T1H);

  logic [NS_W-1:0] ns_nxt;
  logic            dout_nxt;

  always_comb begin
    bit_end  = en && (ns == NS_W'(NSS - 1));
    ns_nxt   = '0;
    if (en && !bit_end) ns_nxt = ns + 1'b1;
    dout_nxt = dout_en && (32'(ns_nxt) < (bit_val ? T1H_U : T0H_U));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ns   <= '0;
      dout <= 1'b0;
    end else begin
      ns   <= ns_nxt;
      dout <= dout_nxt;
    end
  end

endmodule

// File: rtl/ws_frame_sequencer.sv
// WS281x frame sequencer: START/BUSY/DONE handshake, frame-buffer prefetch
// addressing, serial DOUT waveform, latch gap and optional continuous refresh.
module ws_frame_sequencer
  import ws_seq_pkg::*;
#(
  parameter int MAX_PIXELS  = 256,
  parameter int BITS        = 24,
  parameter int NSS         = 64,
  parameter int T0H         = 20,
  parameter int T1H         = 40,
  parameter int LATCH_TICKS = 3200,
  localparam int PIX_W = cnt_w(MAX_PIXELS + 1),
  localparam int BIT_W = cnt_w(BITS),
  localparam int NS_W  = cnt_w(NSS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             CONTINUOUS,
  input  logic [PIX_W-1:0] PIXEL_COUNT,
  input  logic [BITS-1:0]  PIXEL_DATA,
  output logic [PIX_W-1:0] NEXT_ADDR,
  output logic [PIX_W-1:0] PIXEL,
  output logic [BIT_W-1:0] BIT,
  output logic [NS_W-1:0]  NS,
  output logic             DOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam int LAT_W = cnt_w(LATCH_TICKS);

  if (!timing_ok(NSS, T0H, T1H, BITS, LATCH_TICKS)) begin : g_bad_timing
    $error("ws_frame_sequencer: illegal timing parameters");
  end

  state_t           state_q, state_nxt;
  logic [PIX_W-1:0] pixel_q, pixel_nxt;
  logic [BIT_W-1:0] bit_q, bit_nxt;
  logic [BITS-1:0]  shreg_q, shreg_nxt;
  logic [PIX_W-1:0] addr_q, addr_nxt;
  logic [PIX_W-1:0] count_q, count_nxt;
  logic [LAT_W-1:0] lat_q, lat_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             accept;
  logic             bit_end;
  logic             last_pixel;

  assign last_pixel = ((PIX_W + 1)'(pixel_q) + 1'b1) == (PIX_W + 1)'(count_q);

  always_comb begin
    state_nxt = state_q;
    pixel_nxt = pixel_q;
    bit_nxt   = bit_q;
    shreg_nxt = shreg_q;
    addr_nxt  = addr_q;
    count_nxt = count_q;
    lat_nxt   = lat_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        addr_nxt = '0;
        if (START && (PIXEL_COUNT != '0)) accept = 1'b1;
      end
      SEND: begin
        if (bit_end) begin
          shreg_nxt = shreg_q << 1;
          if (bit_q == BIT_W'(BITS - 1)) begin
            bit_nxt = '0;
            if (last_pixel) begin
              state_nxt = LATCH;
              pixel_nxt = '0;
              addr_nxt  = '0;
              lat_nxt   = '0;
            end else begin
              pixel_nxt = pixel_q + 1'b1;
              shreg_nxt = PIXEL_DATA;
              addr_nxt  = addr_q + 1'b1;
            end
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_q == LAT_W'(LATCH_TICKS - 1)) begin
          done_nxt = 1'b1;
          // Continuous refresh reuses the accept path so the next frame starts with no gap.
          if (CONTINUOUS && (PIXEL_COUNT != '0)) begin
            accept = 1'b1;
          end else begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end else begin
          lat_nxt = lat_q + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase

    if (accept) begin
      count_nxt = (PIXEL_COUNT > PIX_W'(MAX_PIXELS)) ? PIX_W'(MAX_PIXELS) : PIXEL_COUNT;
      shreg_nxt = PIXEL_DATA;
      addr_nxt  = PIX_W'(1);
      pixel_nxt = '0;
      bit_nxt   = '0;
      busy_nxt  = 1'b1;
      state_nxt = SEND;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pixel_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      count_q <= '0;
      lat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      pixel_q <= pixel_nxt;
      bit_q   <= bit_nxt;
      shreg_q <= shreg_nxt;
      addr_q  <= addr_nxt;
      count_q <= count_nxt;
      lat_q   <= lat_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  ws_bit_encoder #(
    .NSS (NSS),
    .T0H (T0H),
    .T1H (T1H)
  ) u_enc (
    .CLK     (CLK),
    .RST     (RST),
    .en      (state_q == SEND),
    .dout_en (state_nxt == SEND),
    .bit_val (shreg_nxt[BITS-1]),
    .ns      (NS),
    .dout    (DOUT),
    .bit_end (bit_end)
  );

  assign NEXT_ADDR = addr_q;
  assign PIXEL     = pixel_q;
  assign BIT       = bit_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_ws_frame_sequencer.sv
// Directed bench for ws_frame_sequencer with small timing parameters.
// Checks reset, single/multi-pixel frames, continuous refresh, ignored starts and mid-frame reset.
module tb_ws_frame_sequencer;

  localparam int MAX_PIXELS  = 8;
  localparam int BITS        = 4;
  localparam int NSS         = 8;
  localparam int T0H         = 2;
  localparam int T1H         = 5;
  localparam int LATCH_TICKS = 10;
  localparam int PIX_W       = 4;
  localparam int BIT_W       = 2;
  localparam int NS_W        = 3;

  logic             CLK = 1'b0;
  logic             RST;
  logic             START;
  logic             CONTINUOUS;
  logic [PIX_W-1:0] PIXEL_COUNT;
  logic [BITS-1:0]  PIXEL_DATA;
  logic [PIX_W-1:0] NEXT_ADDR;
  logic [PIX_W-1:0] PIXEL;
  logic [BIT_W-1:0] BIT;
  logic [NS_W-1:0]  NS;
  logic             DOUT;
  logic             BUSY;
  logic             DONE;

  logic [BITS-1:0]  pd_drv;
  logic [BITS-1:0]  ram_q = '0;
  logic             use_ram;

  int checks = 0;
  int errors = 0;

  ws_frame_sequencer #(
    .MAX_PIXELS  (MAX_PIXELS),
    .BITS        (BITS),
    .NSS         (NSS),
    .T0H         (T0H),
    .T1H         (T1H),
    .LATCH_TICKS (LATCH_TICKS)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .CONTINUOUS  (CONTINUOUS),
    .PIXEL_COUNT (PIXEL_COUNT),
    .PIXEL_DATA  (PIXEL_DATA),
    .NEXT_ADDR   (NEXT_ADDR),
    .PIXEL       (PIXEL),
    .BIT         (BIT),
    .NS          (NS),
    .DOUT        (DOUT),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  always #5 CLK = ~CLK;

  // Frame buffer with one cycle of read latency; contents are addr + 5.
  always @(posedge CLK) ram_q <= NEXT_ADDR + 4'd5;
  assign PIXEL_DATA = use_ram ? ram_q : pd_drv;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One pixel of 1010: high runs 5,2,5,2 per 8-tick slot, then 10 latch cycles, then DONE.
  task automatic frame_1010();
    logic [31:0] wave = 32'b11111000_11000000_11111000_11000000;
    use_ram     = 1'b0;
    pd_drv      = 4'b1010;
    PIXEL_COUNT = 4'd1;
    CONTINUOUS  = 1'b0;
    START       = 1'b1;
    chk("idle_addr", 32'(NEXT_ADDR), 32'd0);
    tick();
    START       = 1'b0;
    PIXEL_COUNT = 4'd0;
    pd_drv      = 4'b0101;
    for (int k = 0; k < 32; k++) begin
      chk("dout_1010", 32'(DOUT), 32'(wave[31-k]));
      chk("busy_send", 32'({BUSY, DONE}), 32'b10);
      chk("bit_ns", 32'({BIT, NS}), 32'(k));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      chk("latch_1px", 32'({DOUT, BUSY, DONE}), 32'b010);
      tick();
    end
    chk("done_1px", 32'({DOUT, BUSY, DONE}), 32'b001);
    tick();
    chk("after_1px", 32'({DOUT, BUSY, DONE, NEXT_ADDR}), 32'd0);
  endtask

  initial begin
    logic [3:0] d;
    int         p, b, n, done_seen;

    RST         = 1'b1;
    START       = 1'b0;
    CONTINUOUS  = 1'b0;
    PIXEL_COUNT = '0;
    pd_drv      = '0;
    use_ram     = 1'b0;

    // Reset held 3 cycles, then idle with no START.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", 32'({DOUT, BUSY, DONE, PIXEL, BIT, NS, NEXT_ADDR}), 32'd0);
    end
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_outs", 32'({DOUT, BUSY, DONE, PIXEL, BIT, NS, NEXT_ADDR}), 32'd0);
    end

    frame_1010();

    // Three pixels fetched from the RAM model: data 5, 6, 7.
    use_ram     = 1'b1;
    PIXEL_COUNT = 4'd3;
    tick();
    START = 1'b1;
    chk("ram_addr_pre", 32'(NEXT_ADDR), 32'd0);
    tick();
    START       = 1'b0;
    PIXEL_COUNT = 4'd0;
    for (int k = 0; k < 96; k++) begin
      p = k / 32;
      b = (k / 8) % 4;
      n = k % 8;
      d = 4'(5 + p);
      chk("dout_3px", 32'(DOUT), (n < (d[3-b] ? 5 : 2)) ? 32'd1 : 32'd0);
      chk("pixel_3px", 32'(PIXEL), 32'(p));
      chk("addr_3px", 32'(NEXT_ADDR), 32'(p + 1));
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      chk("latch_3px", 32'({DOUT, BUSY, DONE, NEXT_ADDR}), 32'b010_0000);
      tick();
    end
    chk("done_3px", 32'({BUSY, DONE}), 32'b01);

    // START with a zero count is ignored.
    use_ram     = 1'b0;
    PIXEL_COUNT = 4'd0;
    START       = 1'b1;
    tick();
    START = 1'b0;
    chk("zero_cnt_busy", 32'(BUSY), 32'd0);
    tick();
    chk("zero_cnt_idle", 32'({BUSY, DONE, NEXT_ADDR, NS}), 32'd0);

    // Continuous refresh, two pixels: DONE every 74 cycles; drop CONTINUOUS in frame 3.
    pd_drv      = 4'b0001;
    PIXEL_COUNT = 4'd2;
    CONTINUOUS  = 1'b1;
    START       = 1'b1;
    tick();
    START = 1'b0;
    for (int c = 1; c <= 230; c++) begin
      if (c == 160) CONTINUOUS = 1'b0;
      if (c == 75 || c == 149 || c == 223) chk("cont_done", 32'(DONE), 32'd1);
      else chk("cont_nodone", 32'(DONE), 32'd0);
      if (c == 75 || c == 149)
        chk("cont_restart", 32'({BUSY, DOUT, NS, PIXEL, BIT}), 32'b11_000_0000_00 << 0 | 32'd0 | (32'b11 << 9));
      if (c >= 223) chk("cont_stop", 32'(BUSY), 32'd0);
      tick();
    end

    // START during SEND is ignored; then reset in the middle of pixel 2.
    use_ram     = 1'b1;
    PIXEL_COUNT = 4'd3;
    START       = 1'b1;
    tick();
    for (int k = 0; k < 70; k++) begin
      START       = (k >= 9 && k <= 11);
      PIXEL_COUNT = START ? 4'd1 : 4'd3;
      chk("restart_ignored", 32'({PIXEL, BIT, NS}), 32'(((k / 32) << 5) | (k % 32)));
      tick();
    end
    START = 1'b0;
    chk("pre_rst_pixel", 32'(PIXEL), 32'd2);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("mid_rst_outs", 32'({DOUT, BUSY, DONE, PIXEL, BIT, NS, NEXT_ADDR}), 32'd0);
    done_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (DONE || BUSY) done_seen++;
    end
    chk("no_done_after_rst", 32'(done_seen), 32'd0);

    frame_1010();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
